// File: rtl/dmem_pkg.sv
// dmem_pkg
//   Shared definitions for the data-memory responder: the memory-mapped I/O
//   addresses, the STATUS register bit layout, the region-select enum and the
//   address decoder used by data_mem_responder.
package dmem_pkg;

  localparam logic [31:0] IO_BASE     = 32'hFFFF_0000;
  localparam logic [31:0] TXDATA_ADDR = IO_BASE + 32'h0;
  localparam logic [31:0] STATUS_ADDR = IO_BASE + 32'h4;
  localparam logic [31:0] CYCLE_ADDR  = IO_BASE + 32'h8;
  localparam logic [31:0] DROPS_ADDR  = IO_BASE + 32'hC;

  // STATUS layout: bit0 empty, bit1 full, bits[8:4] FIFO occupancy.
  localparam int STATUS_EMPTY_BIT = 0;
  localparam int STATUS_FULL_BIT  = 1;
  localparam int STATUS_COUNT_LSB = 4;
  localparam int STATUS_COUNT_MSB = 8;

  typedef enum logic [2:0] {
    REG_RAM,
    REG_TX,
    REG_STATUS,
    REG_CYCLE,
    REG_DROPS,
    REG_NONE
  } region_e;

  // Byte-address decode; the two low address bits never affect the result.
  // The RAM check compares the full word address against the RAM size, so an
  // address past the end cannot alias back onto a RAM word.
  function automatic region_e decodeRegion(input logic [31:0] addr,
                                           input int unsigned depthWords);
    logic [31:0] wordAligned;
    wordAligned = {addr[31:2], 2'b00};
    if ({2'b00, addr[31:2]} < depthWords) return REG_RAM;
    if (wordAligned == TXDATA_ADDR)       return REG_TX;
    if (wordAligned == STATUS_ADDR)       return REG_STATUS;
    if (wordAligned == CYCLE_ADDR)        return REG_CYCLE;
    if (wordAligned == DROPS_ADDR)        return REG_DROPS;
    return REG_NONE;
  endfunction

endpackage

// File: rtl/data_mem_responder_tx_fifo.sv
// tx_fifo
//   Circular-buffer FIFO with occupancy count.
//   Ports:
//     clk, reset     clock, asynchronous active-low reset (pointers/count only)
//     push, pushData write request and data; ignored when full
//     pop            read request; ignored when empty
//     popData        head entry, forced to 0 while empty
//     full, empty    derived from the registered count
//     count          current occupancy, 0..DEPTH
//   A push into an empty FIFO becomes visible at popData on the next cycle
//   (no bypass). Simultaneous push and pop with 0 < count < DEPTH leaves the
//   count unchanged.
module tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] popData,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [CNT_W-1:0] countQ;
  logic             doPush;
  logic             doPop;

  assign full   = (countQ == CNT_W'(DEPTH));
  assign empty  = (countQ == '0);
  assign count  = countQ;
  // Full/empty come from the pre-edge count, so a push while full is lost
  // even if a pop happens on the same edge.
  assign doPush = push && !full;
  assign doPop  = pop && !empty;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr  <= '0;
      rdPtr  <= '0;
      countQ <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   countQ <= countQ + 1'b1;
        2'b01:   countQ <= countQ - 1'b1;
        default: countQ <= countQ;
      endcase
    end
  end

  // Storage is not reset; an empty FIFO masks it at the output instead.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

  assign popData = empty ? '0 : mem[rdPtr];

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Data-memory responder for the core's M stage: word-addressed RAM plus an
//   I/O window holding a TX byte FIFO, a free-running cycle counter and a
//   dropped-write counter.
//   Ports:
//     clk, reset   clock, asynchronous active-low reset
//     MemWriteM    write strobe for this cycle
//     ALUResultM   byte address (bits [1:0] ignored)
//     WriteDataM   store data
//     ReadDataM    load data, combinational (same-cycle) from address/state
//     tx_valid     FIFO head valid
//     tx_data      FIFO head byte
//     tx_ready     sink accepts head this cycle
//   Stream handshake: a byte transfers on every rising edge where tx_valid
//   and tx_ready are both high; while tx_valid && !tx_ready, tx_data holds.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  region_e           region;
  logic [IDX_W-1:0]  ramIdx;
  logic [31:0]       ram [DEPTH_WORDS];
  logic [31:0]       cycleCount;
  logic [15:0]       dropCount;
  logic [31:0]       status;
  logic              txPush;
  logic              txDrop;
  logic              txFull;
  logic              txEmpty;
  logic [CNT_W-1:0]  txCount;

  assign region = decodeRegion(ALUResultM, DEPTH_WORDS);
  assign ramIdx = ALUResultM[IDX_W+1:2];

  // RAM: asynchronous read, write on the edge ending the access, no reset.
  always_ff @(posedge clk) begin
    if (MemWriteM && (region == REG_RAM)) ram[ramIdx] <= WriteDataM;
  end

  assign txPush = MemWriteM && (region == REG_TX);
  assign txDrop = txPush && txFull;

  tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (txPush),
    .pushData (WriteDataM[7:0]),
    .pop      (tx_ready),
    .popData  (tx_data),
    .full     (txFull),
    .empty    (txEmpty),
    .count    (txCount)
  );

  assign tx_valid = !txEmpty;

  // A CYCLE write replaces that edge's increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycleCount <= '0;
    end else if (MemWriteM && (region == REG_CYCLE)) begin
      cycleCount <= WriteDataM;
    end else begin
      cycleCount <= cycleCount + 32'd1;
    end
  end

  // Clear wins over a drop; with one access per cycle they never coincide.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dropCount <= '0;
    end else if (MemWriteM && (region == REG_DROPS)) begin
      dropCount <= '0;
    end else if (txDrop && (dropCount != 16'hFFFF)) begin
      dropCount <= dropCount + 16'd1;
    end
  end

  always_comb begin
    status = '0;
    status[STATUS_EMPTY_BIT] = txEmpty;
    status[STATUS_FULL_BIT]  = txFull;
    status[STATUS_COUNT_MSB:STATUS_COUNT_LSB] = 5'(txCount);
  end

  always_comb begin
    ReadDataM = '0;
    case (region)
      REG_RAM:    ReadDataM = ram[ramIdx];
      REG_STATUS: ReadDataM = status;
      REG_CYCLE:  ReadDataM = cycleCount;
      REG_DROPS:  ReadDataM = {16'h0000, dropCount};
      default:    ReadDataM = '0;
    endcase
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Responder for the core's data-memory port: receives the M-stage address/write-data/write-enable triple and returns read data in the same cycle. Decodes a word-addressed RAM plus a small memory-mapped I/O window. The window holds a transmit FIFO drained over a valid/ready byte stream, a free-running cycle counter and a dropped-write counter. Sits beside the core at top level, between the core's data port and the board-level debug output.

## Interface
- DEPTH_WORDS, 64, RAM size in 32-bit words; power of two, ≥4
- FIFO_DEPTH, 8, TX FIFO entries; power of two, 2..16
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- MemWriteM  in  1  write strobe for the current cycle
- ALUResultM  in  32  byte address; bits [1:0] ignored
- WriteDataM  in  32  store data
- ReadDataM  out  32  load data, combinational from address and current state
- tx_valid  out  1  FIFO head valid
- tx_data  out  8  FIFO head byte
- tx_ready  in  1  sink accepts head this cycle

## Operation
- Address map (word-aligned):
  - 0x0000_0000 to DEPTH_WORDS*4-1: RAM
  - 0xFFFF_0000 TXDATA
  - 0xFFFF_0004 STATUS
  - 0xFFFF_0008 CYCLE
  - 0xFFFF_000C DROPS
  - Anything else reads 0; writes to it are ignored.
- RAM
  - Read is asynchronous. Write occurs at the clk edge when MemWriteM=1.
  - Index = ALUResultM[log2(DEPTH_WORDS)+1:2], used only when the address is in range. No aliasing.
  - Contents are not reset.
- TXDATA
  - Write pushes WriteDataM[7:0] if the FIFO is not full. If full, the byte is discarded and DROPS increments.
  - Read returns 0.
- STATUS (read-only)
  - bit0 = empty, bit1 = full, bits[8:4] = occupancy count, other bits 0.
  - Writes are ignored.
- CYCLE
  - 32-bit counter, +1 every cycle, wraps 0xFFFF_FFFF→0.
  - A write loads WriteDataM; there is no increment on that edge.
  - A read returns the pre-edge value.
- DROPS
  - 16-bit counter, saturates at 0xFFFF, zero-extended on read.
  - Any write clears it to 0. A clear has priority over a simultaneous drop; this cannot actually co-occur because there is one access per cycle.
- FIFO rules
  - Pop occurs when tx_valid && tx_ready.
  - tx_valid = !empty. tx_data = head entry; it stays stable while tx_valid && !tx_ready.
  - Push and pop in the same cycle with 0 < count < FIFO_DEPTH: count unchanged, data order preserved.
  - When full, a push in the same cycle as a pop is still dropped. Full is evaluated on the pre-edge count.
  - No bypass: a push into an empty FIFO raises tx_valid on the next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset values (asynchronous on reset=0)
  - FIFO pointers and count = 0, so tx_valid=0 and tx_data=0.
  - CYCLE=0, DROPS=0.
  - ReadDataM follows the decode: for example, STATUS reads 0x1.
  - Asserting reset mid-stream discards all FIFO contents; a byte offered but not yet accepted is lost.

## Timing
- Load latency 0: ReadDataM settles in the same cycle the address is presented, as the core's M stage requires.
- Store, FIFO push, CYCLE load and DROPS update all take effect on the clk edge that ends the access cycle. A read in the following cycle sees the new value.
- Reads of STATUS, CYCLE and DROPS reflect the registered state before that cycle's edge.
- Pop takes effect on the accepting edge. The next head appears in the following cycle.
- The sink may hold tx_ready high indefinitely: one byte per cycle is sustained.

## Structure
- Package dmem_pkg holds:
  - the address constants TXDATA_ADDR, STATUS_ADDR, CYCLE_ADDR, DROPS_ADDR and IO_BASE=0xFFFF_0000
  - the STATUS bit positions
  - a region-select enum {REG_RAM, REG_TX, REG_STATUS, REG_CYCLE, REG_DROPS, REG_NONE}
- One sub-module: tx_fifo, parameterised by width and depth, exposing push/pop/full/empty/count.
- The decode, the counters and the RAM live in data_mem_responder.

## Test plan
- Write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0010 and 0x0000_0013 → both return 0xDEADBEEF. Read 0x0000_0100 with DEPTH_WORDS=64 → 0.
- tx_ready=0; push 9 bytes 0x41..0x49 → STATUS reads full=1, count=8. DROPS=1. tx_data=0x41 held stable over 5 cycles.
- Raise tx_ready=1 and push 0x50 in the same cycle the FIFO is full → 0x50 dropped, DROPS=2. Output sequence is 0x41..0x48, then tx_valid=0 and STATUS=0x1.
- Write CYCLE=0xFFFF_FFFE → reads 0xFFFF_FFFE, 0xFFFF_FFFF and 0x0 on consecutive cycles. Write DROPS (any data) → DROPS reads 0.
- Fill 3 bytes, then pull reset low mid-transfer → tx_valid drops immediately (asynchronously). After release: STATUS=0x1, CYCLE counts from 0, and a RAM word written before reset still reads back.
